// File: rtl/pci_bus_arbiter_if.sv
// Arbitration bundle for the PCI arbiter: REQ#/GNT# lines, FRAME#/IRDY# and ownership status.
// "master" is the initiator side, "slave" is the arbiter side.
interface pci_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int OWN_W       = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] req_n;
  logic                   frame_n;
  logic                   irdy_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [OWN_W-1:0]       owner;
  logic                   owner_vld;
  logic                   bus_idle;

  modport master (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, owner_vld, bus_idle
  );

  modport slave (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, owner_vld, bus_idle
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout, latency-timer preemption and turnaround.
// Define PCI_ARB_PARK_EN to park the idle grant on master 0.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int OWN_W       = $clog2(NUM_MASTERS)
) (
  input  logic              clk,
  input  logic              reset_n,
  pci_bus_arbiter_if.slave  bus
);

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  localparam int TMR_W = $clog2(GNT_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] gnt_n, gnt_n_nxt;
  logic [OWN_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [OWN_W-1:0]       owner, owner_nxt;
  logic                   owner_vld, owner_vld_nxt;
  logic                   bus_idle;
  logic [TMR_W-1:0]       timer, timer_nxt;

  logic [OWN_W-1:0]       winner, cand;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] owner_oh, grant_vec;
  logic                   others_req, park_break;

  // Walk from the highest offset down so the requester closest to rr_ptr is kept last.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = OWN_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!bus.req_n[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign owner_oh   = NUM_MASTERS'(1) << owner;
  assign grant_vec  = ~(NUM_MASTERS'(1) << winner);
  assign others_req = |(~bus.req_n & ~owner_oh);
  assign park_break = |(~bus.req_n[NUM_MASTERS-1:1]);

  always_comb begin
    state_nxt     = state;
    gnt_n_nxt     = gnt_n;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    owner_vld_nxt = owner_vld;
    timer_nxt     = timer;
    unique case (state)
      IDLE: begin
        // In IDLE a low gnt_n[0] can only mean the grant is parked.
        if (PARK_EN && !gnt_n[0] && !bus.frame_n) begin
          state_nxt     = BUSY;
          owner_nxt     = '0;
          owner_vld_nxt = 1'b1;
        end else if (PARK_EN && !gnt_n[0] && park_break) begin
          gnt_n_nxt = '1;
        end else if (any_req && bus_idle) begin
          state_nxt  = GRANT;
          gnt_n_nxt  = grant_vec;
          owner_nxt  = winner;
          rr_ptr_nxt = (winner == OWN_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
          timer_nxt  = '0;
        end else if (PARK_EN && bus_idle) begin
          gnt_n_nxt = {{(NUM_MASTERS-1){1'b1}}, 1'b0};
          owner_nxt = '0;
        end
      end
      GRANT: begin
        if (!bus.frame_n) begin
          state_nxt     = BUSY;
          owner_vld_nxt = 1'b1;
        end else if (bus.req_n[owner] || timer == TMR_LAST) begin
          state_nxt = IDLE;
          gnt_n_nxt = '1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      BUSY: begin
        if (bus.frame_n && bus.irdy_n) begin
          state_nxt     = TURN;
          gnt_n_nxt     = '1;
          owner_vld_nxt = 1'b0;
        end else if (others_req || bus.req_n[owner]) begin
          gnt_n_nxt = '1;
        end
      end
      TURN: begin
        state_nxt = IDLE;
        gnt_n_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_n     <= '1;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      bus_idle  <= 1'b1;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      gnt_n     <= gnt_n_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      owner_vld <= owner_vld_nxt;
      bus_idle  <= bus.frame_n & bus.irdy_n;
      timer     <= timer_nxt;
    end
  end

  assign bus.gnt_n     = gnt_n;
  assign bus.owner     = owner;
  assign bus.owner_vld = owner_vld;
  assign bus.bus_idle  = bus_idle;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: directed scenarios plus random traffic
// checked against a behavioural arbitration model.
module tb_pci_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int OW = $clog2(N);

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  pci_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  pci_bus_arbiter #(.NUM_MASTERS(N), .GNT_TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the grant (-1 = nobody), phase 0 waiting / 1 granted /
  // 2 transfer / 3 turnaround, and the round-robin start point.
  int            m_phase;
  int            m_gnt;
  int            m_wait;
  logic [OW-1:0] m_owner;
  logic [OW-1:0] m_ptr;
  bit            m_vld;
  bit            m_idle;
  bit            m_parked;

  task automatic model_reset();
    m_phase = 0; m_gnt = -1; m_wait = 0; m_owner = '0; m_ptr = '0;
    m_vld = 1'b0; m_idle = 1'b1; m_parked = 1'b0;
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '1;
    if (m_gnt >= 0) g[OW'(m_gnt)] = 1'b0;
    return g;
  endfunction

  function automatic int low_idx(input logic [N-1:0] g);
    logic [N-1:0] t;
    int idx;
    t = g;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (idx < 0 && !t[0]) idx = i;
      t = t >> 1;
    end
    return idx;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic fr, input logic ir);
    bit           was_idle;
    int           win;
    logic [2*N-1:0] rot;
    logic [N-1:0] only_owner;
    was_idle = m_idle;
    m_idle   = fr & ir;
    rot = {req, req} >> m_ptr;
    win = -1;
    for (int d = 0; d < N; d++) begin
      if (win < 0 && !rot[0]) win = (int'(m_ptr) + d) % N;
      rot = rot >> 1;
    end
    only_owner = '1;
    only_owner[m_owner] = 1'b0;
    case (m_phase)
      0: begin
        if (PARK && m_parked && !fr) begin
          m_phase = 2; m_vld = 1'b1; m_owner = '0; m_parked = 1'b0;
        end else if (PARK && m_parked && req[N-1:1] != '1) begin
          m_gnt = -1; m_parked = 1'b0;
        end else if (win >= 0 && was_idle) begin
          m_gnt = win; m_owner = OW'(win); m_ptr = OW'((win + 1) % N);
          m_wait = 0; m_phase = 1; m_parked = 1'b0;
        end else if (PARK && was_idle) begin
          m_gnt = 0; m_owner = '0; m_parked = 1'b1;
        end
      end
      1: begin
        if (!fr) begin
          m_phase = 2; m_vld = 1'b1;
        end else if (req[m_owner] || m_wait == TO - 1) begin
          m_phase = 0; m_gnt = -1;
        end else begin
          m_wait++;
        end
      end
      2: begin
        if (fr && ir) begin
          m_phase = 3; m_gnt = -1; m_vld = 1'b0;
        end else if (req != only_owner) begin
          m_gnt = -1;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // Drive one cycle of bus inputs, clock it, advance the model, and settle past the edge.
  task automatic cycle(input logic [N-1:0] r, input logic f, input logic i);
    bus.req_n   = r;
    bus.frame_n = f;
    bus.irdy_n  = i;
    @(posedge clk);
    model_step(r, f, i);
    #1;
  endtask

  task automatic do_reset();
    bus.req_n = '1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_n = 4'b0000; bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.bus_idle !== 1'b1 || bus.owner !== 2'd0)
      $display("[TB] FAIL reset_hold: gnt_n=%b vld=%b idle=%b owner=%0d, want 1111 0 1 0", bus.gnt_n, bus.owner_vld, bus.bus_idle, bus.owner);
    else n_pass++;
    reset_n = 1'b1;
    cycle(4'b0000, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b1110 || bus.owner !== 2'd0)
      $display("[TB] FAIL reset_release: gnt_n=%b owner=%0d, want 1110 0", bus.gnt_n, bus.owner);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int idx;
    int budget;
    for (int n = 0; n < 5; n++) begin
      budget = 0;
      while (bus.gnt_n === 4'b1111 && budget < 8) begin
        cycle(4'b0000, 1'b1, 1'b1);
        budget++;
      end
      idx = low_idx(bus.gnt_n);
      n_checks++;
      if (idx !== n % N || bus.owner !== OW'(n % N) || $countones(~bus.gnt_n) != 1)
        $display("[TB] FAIL rr_order[%0d]: gnt_n=%b owner=%0d, want master %0d", n, bus.gnt_n, bus.owner, n % N);
      else n_pass++;
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      n_checks++;
      if (bus.owner_vld !== 1'b1 || bus.gnt_n !== 4'b1111)
        $display("[TB] FAIL rr_busy_preempt[%0d]: vld=%b gnt_n=%b, want 1 1111", n, bus.owner_vld, bus.gnt_n);
      else n_pass++;
      cycle(4'b0000, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b1);
      n_checks++;
      if (bus.owner_vld !== 1'b0 || bus.gnt_n !== 4'b1111)
        $display("[TB] FAIL rr_turn[%0d]: vld=%b gnt_n=%b, want 0 1111", n, bus.owner_vld, bus.gnt_n);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    cycle(4'b1011, 1'b1, 1'b1);
    cnt = 0;
    while (bus.gnt_n === 4'b1011 && cnt < 40) begin
      cnt++;
      cycle(4'b1011, 1'b1, 1'b1);
    end
    n_checks++;
    if (cnt != TO || bus.gnt_n !== 4'b1111)
      $display("[TB] FAIL timeout_len: low for %0d cycles then gnt_n=%b, want %0d then 1111", cnt, bus.gnt_n, TO);
    else n_pass++;
    cycle(4'b0011, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b0111 || bus.owner !== 2'd3)
      $display("[TB] FAIL timeout_rr_ptr: gnt_n=%b owner=%0d, want 0111 3", bus.gnt_n, bus.owner);
    else n_pass++;
    cycle(4'b1111, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b1111)
      $display("[TB] FAIL grant_withdrawn: gnt_n=%b, want 1111", bus.gnt_n);
    else n_pass++;
  endtask

  task automatic test_preemption();
    cycle(4'b1101, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b1101)
      $display("[TB] FAIL preempt_grant1: gnt_n=%b, want 1101", bus.gnt_n);
    else n_pass++;
    cycle(4'b1101, 1'b0, 1'b0);
    cycle(4'b1101, 1'b0, 1'b0);
    n_checks++;
    if (bus.gnt_n !== 4'b1101 || bus.owner_vld !== 1'b1)
      $display("[TB] FAIL preempt_busy_hold: gnt_n=%b vld=%b, want 1101 1", bus.gnt_n, bus.owner_vld);
    else n_pass++;
    cycle(4'b0101, 1'b0, 1'b0);
    n_checks++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_vld !== 1'b1)
      $display("[TB] FAIL preempt_drop: gnt_n=%b vld=%b, want 1111 1", bus.gnt_n, bus.owner_vld);
    else n_pass++;
    cycle(4'b0101, 1'b1, 1'b0);
    cycle(4'b0101, 1'b1, 1'b1);
    n_checks++;
    if (bus.owner_vld !== 1'b0 || bus.bus_idle !== 1'b1 || bus.gnt_n !== 4'b1111)
      $display("[TB] FAIL preempt_end: vld=%b idle=%b gnt_n=%b, want 0 1 1111", bus.owner_vld, bus.bus_idle, bus.gnt_n);
    else n_pass++;
    cycle(4'b0111, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b1111)
      $display("[TB] FAIL preempt_turn: gnt_n=%b, want 1111", bus.gnt_n);
    else n_pass++;
    cycle(4'b0111, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== 4'b0111 || bus.owner !== 2'd3)
      $display("[TB] FAIL preempt_next: gnt_n=%b owner=%0d, want 0111 3", bus.gnt_n, bus.owner);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(4'b1110, 1'b1, 1'b1);
    cycle(4'b1110, 1'b0, 1'b0);
    n_checks++;
    if (bus.owner_vld !== 1'b1 || bus.gnt_n !== 4'b1110)
      $display("[TB] FAIL async_setup: vld=%b gnt_n=%b, want 1 1110", bus.owner_vld, bus.gnt_n);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt_n !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.bus_idle !== 1'b1)
      $display("[TB] FAIL async_reset: gnt_n=%b vld=%b idle=%b, want 1111 0 1", bus.gnt_n, bus.owner_vld, bus.bus_idle);
    else n_pass++;
    model_reset();
    bus.frame_n = 1'b1; bus.irdy_n = 1'b1; bus.req_n = '1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_parking();
    do_reset();
    cycle(4'b1111, 1'b1, 1'b1);
    n_checks++;
    if (bus.gnt_n !== (PARK ? 4'b1110 : 4'b1111))
      $display("[TB] FAIL park_idle: gnt_n=%b, want %b", bus.gnt_n, PARK ? 4'b1110 : 4'b1111);
    else n_pass++;
    cycle(4'b1011, 1'b1, 1'b1);
    if (PARK) begin
      n_checks++;
      if (bus.gnt_n !== 4'b1111)
        $display("[TB] FAIL park_release: gnt_n=%b, want 1111", bus.gnt_n);
      else n_pass++;
      cycle(4'b1011, 1'b1, 1'b1);
    end
    n_checks++;
    if (bus.gnt_n !== 4'b1011)
      $display("[TB] FAIL park_grant2: gnt_n=%b, want 1011", bus.gnt_n);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         f;
    logic         i;
    int           prev;
    int           cur;
    do_reset();
    prev = -1;
    for (int c = 0; c < 600; c++) begin
      r = N'($urandom) | N'($urandom);
      f = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      i = 1'(($urandom_range(0, 1)));
      cycle(r, f, i);
      n_checks++;
      if ({bus.gnt_n, bus.owner, bus.owner_vld, bus.bus_idle} !== {exp_gnt(), m_owner, m_vld, m_idle})
        $display("[TB] FAIL rand_model[%0d]: gnt_n=%b owner=%0d vld=%b idle=%b, want %b %0d %b %b",
                 c, bus.gnt_n, bus.owner, bus.owner_vld, bus.bus_idle, exp_gnt(), m_owner, m_vld, m_idle);
      else n_pass++;
      cur = low_idx(bus.gnt_n);
      n_checks++;
      if ($countones(~bus.gnt_n) > 1 || (prev >= 0 && cur >= 0 && prev != cur))
        $display("[TB] FAIL rand_one_grant[%0d]: gnt_n=%b prev owner %0d, want single grant and gap between owners", c, bus.gnt_n, prev);
      else n_pass++;
      prev = cur;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_preemption();
    test_async_reset();
    test_parking();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI bus arbiter that shares one bus between up to NUM_MASTERS initiators, each a Controller-style initiator with req/gnt pins.
- Samples active-low REQ# lines and grants the bus round-robin, one GNT# at a time.
- Tracks bus ownership from FRAME#/IRDY#, and reclaims grants that go unused or are abandoned.
- Sits at the top of the PCI subsystem, beside the initiators and targets.

Parameters:
- NUM_MASTERS, 4, number of requesting initiators (2..8).
- GNT_TIMEOUT, 16, number of cycles a granted master may leave FRAME# unasserted before the grant is withdrawn (>=2).
- OWN_W, $clog2(NUM_MASTERS), width of the owner index.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_n  input  NUM_MASTERS  per-master request, active low.
- frame_n  input  1  PCI FRAME#, active low.
- irdy_n  input  1  PCI IRDY#, active low.
- gnt_n  output  NUM_MASTERS  per-master grant, active low, registered.
- owner  output  OWN_W  index of current/last granted master.
- owner_vld  output  1  high while the granted master owns an active transaction.
- bus_idle  output  1  registered (frame_n & irdy_n) from the previous edge.

Behaviour:
- Reset (async, reset_n=0): gnt_n all 1, state IDLE, rr_ptr=0, owner=0, owner_vld=0, bus_idle=1, timer=0. Outputs take reset values immediately, including mid-transaction.
- Invariant: at most one gnt_n bit low in any cycle. A grant never moves directly from master A to master B; at least one cycle with all gnt_n=1 separates them.
- Round-robin winner: the first k with req_n[k]=0, searching rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
  - On grant, rr_ptr <= (k+1) mod NUM_MASTERS.
  - Wrap-around: with NUM_MASTERS=4, rr_ptr=3 and requesters {0,3}, master 3 wins and rr_ptr becomes 0.
- States: IDLE, GRANT, BUSY, TURN.
- IDLE:
  - If any req_n is low and bus_idle=1, register gnt_n[k]=0, owner=k, timer=0, then go to GRANT.
  - Latency: req_n sampled low at edge t gives gnt_n low after edge t.
  - If the bus is not idle, wait in IDLE.
- GRANT:
  - frame_n sampled low: go to BUSY, owner_vld=1.
  - Else req_n[owner] sampled high: gnt_n all 1, go to IDLE.
  - Else timer==GNT_TIMEOUT-1: gnt_n all 1, go to IDLE. rr_ptr is already advanced, so a stuck master loses priority.
  - Else timer++.
  - If frame_n low and req_n[owner] high occur on the same edge, frame_n wins (BUSY).
- BUSY:
  - If any other req_n is low, or req_n[owner] is high, deassert gnt_n[owner] (latency-timer preemption). The transaction continues.
  - When frame_n=1 and irdy_n=1 are sampled (last data phase done), go to TURN with gnt_n all 1 and owner_vld=0.
- TURN: one turnaround cycle, gnt_n all 1, then IDLE.
- Back-to-back: master A finishes, then TURN, then IDLE grants B. This gives at least 2 cycles between bus idle and gnt_n[B] low.
- timer saturates and clears on every entry to GRANT.

Optional Feature:
- Macro: PCI_ARB_PARK_EN.
- Defined: when no req_n is low in IDLE and the bus is idle, park the grant on master 0 (gnt_n[0]=0) without entering GRANT.
  - The timeout does not apply while parked.
  - If master 0 asserts FRAME# while parked, go to BUSY.
  - If another master requests, remove the park for one cycle, then grant normally.
- Undefined: all gnt_n stay 1 while there are no requests.

Test Plan:
- Reset: hold reset_n=0 with req_n=4'b0000, then release. Required: gnt_n=4'b1111 during reset; after release, gnt_n=4'b1110, owner=0.
- Round-robin: req_n=4'b0000 held, each master runs a 3-cycle FRAME# transaction. Required grant order 0,1,2,3,0 and never two gnt_n bits low.
- Timeout: master 2 requests but never asserts frame_n (GNT_TIMEOUT=16). Required: gnt_n[2] low for exactly 16 cycles, then 4'b1111, and rr_ptr=3.
- Preemption: master 1 in BUSY, master 3 drops req_n. Required: gnt_n[1]=1 next cycle, owner_vld stays 1 until frame_n=irdy_n=1, one TURN cycle, then gnt_n=4'b0111.
- Async reset mid-BUSY: reset_n=0 asynchronously. Required: gnt_n=4'b1111 and owner_vld=0 before the next clk edge.
- PCI_ARB_PARK_EN: with no requests, gnt_n=4'b1110. When master 2 requests: 4'b1111 for one cycle, then 4'b1011.
